// File: rtl/ctr_nt_pkg.sv
// Shared definitions for the N-phase time-redundant recovery controller:
// state encoding, legal parameter ranges, defaults and internal widths.
package ctr_nt_pkg;

   typedef enum logic [1:0] {
      ST_NORMAL   = 2'd0,
      ST_ROLLBACK = 2'd1,
      ST_SPEED    = 2'd2,
      ST_PERM     = 2'd3
   } state_t;

   localparam int unsigned NPHASE_MIN = 2;
   localparam int unsigned NPHASE_MAX = 4;
   localparam int unsigned SPEED_MIN  = 3;
   localparam int unsigned SPEED_MAX  = 8;
   localparam int unsigned RETRY_MIN  = 1;
   localparam int unsigned RETRY_MAX  = 15;

   localparam int unsigned NPHASE_DEF = 2;
   localparam int unsigned SPEED_DEF  = 3;
   localparam int unsigned RETRY_DEF  = 3;
   localparam int unsigned CW_DEF     = 8;

   // Sized to cover the largest legal parameter values.
   localparam int unsigned PHASE_W = 2;
   localparam int unsigned K_W     = 3;
   localparam int unsigned RETRY_W = 4;

endpackage

// File: rtl/ctr_nt_satcnt.sv
// Saturating CW-bit event counter; holds at all-ones instead of wrapping.
module ctr_nt_satcnt #(
   parameter int unsigned CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   output logic [CW-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != {CW{1'b1}})) begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/ctr_nt_recovery.sv
// Time-redundant execution controller: checks once per round, rolls back and
// speeds up on a detected fail, and latches a permanent fault after repeated fails.
module ctr_nt_recovery
   import ctr_nt_pkg::*;
#(
   parameter int unsigned NPHASE       = NPHASE_DEF,
   parameter int unsigned SPEED_CYCLES = SPEED_DEF,
   parameter int unsigned MAX_RETRY    = RETRY_DEF,
   parameter int unsigned CW           = CW_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               fail,
   output logic               save,
   output logic               rollBack,
   output logic               readBuff,
   output logic               substr,
   output logic [PHASE_W-1:0] phase,
   output logic               recovering,
   output logic               permFail,
   output logic [CW-1:0]      errCnt
);

   if (NPHASE < NPHASE_MIN || NPHASE > NPHASE_MAX ||
       SPEED_CYCLES < SPEED_MIN || SPEED_CYCLES > SPEED_MAX ||
       MAX_RETRY < RETRY_MIN || MAX_RETRY > RETRY_MAX || CW < 1) begin : g_param_err
      $error("ctr_nt_recovery: parameter outside legal range");
   end

   state_t               state, state_nxt;
   logic [PHASE_W-1:0]   phase_nxt;
   logic [K_W-1:0]       k, k_nxt;
   logic [RETRY_W-1:0]   retry, retry_nxt;
   logic                 save_nxt, rollback_nxt, readbuff_nxt, substr_nxt, perm_nxt;
   logic                 err_inc_c;

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_NORMAL;
         phase      <= '0;
         k          <= '0;
         retry      <= '0;
         save       <= 1'b0;
         rollBack   <= 1'b0;
         readBuff   <= 1'b0;
         substr     <= 1'b0;
         recovering <= 1'b0;
         permFail   <= 1'b0;
      end else begin
         state      <= state_nxt;
         phase      <= phase_nxt;
         k          <= k_nxt;
         retry      <= retry_nxt;
         save       <= save_nxt;
         rollBack   <= rollback_nxt;
         readBuff   <= readbuff_nxt;
         substr     <= substr_nxt;
         recovering <= rollback_nxt;
         permFail   <= perm_nxt;
      end
   end

   // Next-state and next-output logic; fail only matters at the check phase.
   always_comb begin
      state_nxt    = state;
      phase_nxt    = phase;
      k_nxt        = k;
      retry_nxt    = retry;
      save_nxt     = save;
      rollback_nxt = rollBack;
      readbuff_nxt = readBuff;
      substr_nxt   = substr;
      perm_nxt     = permFail;
      err_inc_c    = 1'b0;

      case (state)
         ST_NORMAL: begin
            if (phase == '0) begin
               if (!fail) begin
                  phase_nxt = PHASE_W'(1);
                  save_nxt  = 1'b1;
                  retry_nxt = '0;
               end else if (retry == RETRY_W'(MAX_RETRY - 1)) begin
                  state_nxt    = ST_PERM;
                  save_nxt     = 1'b0;
                  rollback_nxt = 1'b0;
                  readbuff_nxt = 1'b0;
                  substr_nxt   = 1'b0;
                  perm_nxt     = 1'b1;
                  err_inc_c    = 1'b1;
               end else begin
                  state_nxt    = ST_ROLLBACK;
                  save_nxt     = 1'b1;
                  rollback_nxt = 1'b1;
                  readbuff_nxt = 1'b1;
                  substr_nxt   = 1'b1;
                  retry_nxt    = retry + RETRY_W'(1);
                  err_inc_c    = 1'b1;
               end
            end else begin
               save_nxt  = 1'b0;
               phase_nxt = (phase == PHASE_W'(NPHASE - 1)) ? '0 : phase + PHASE_W'(1);
            end
         end
         ST_ROLLBACK: begin
            save_nxt  = 1'b0;
            k_nxt     = '0;
            state_nxt = ST_SPEED;
         end
         ST_SPEED: begin
            k_nxt = k + K_W'(1);
            if (k == K_W'(0)) readbuff_nxt = 1'b0;
            if (k == K_W'(1)) substr_nxt = 1'b0;
            if (k == K_W'(SPEED_CYCLES - 1)) begin
               rollback_nxt = 1'b0;
               readbuff_nxt = 1'b0;
               substr_nxt   = 1'b0;
               save_nxt     = 1'b1;
               k_nxt        = '0;
               phase_nxt    = PHASE_W'(1);
               state_nxt    = ST_NORMAL;
            end
         end
         ST_PERM: begin
            state_nxt = ST_PERM;
         end
         default: begin
            state_nxt = ST_NORMAL;
         end
      endcase
   end

   ctr_nt_satcnt #(.CW(CW)) u_errcnt (
      .clk   (clk),
      .rst_n (reset),
      .inc   (err_inc_c),
      .count (errCnt)
   );

endmodule

// File: doc/ctr_nt_recovery.md
CTR_NT_RECOVERY -- requirements
Module: ctr_nt_recovery

Interface
REQ-001 Parameter NPHASE, default 2: time-redundancy factor (phases per round), legal range 2..4.
REQ-002 Parameter SPEED_CYCLES, default 3: recovery speed-up length in cycles, legal range 3..8.
REQ-003 Parameter MAX_RETRY, default 3: consecutive detected fails before declaring a permanent fault, legal range 1..15.
REQ-004 Parameter CW, default 8: width of the error event counter.
REQ-005 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port fail, input, 1: error-detection flag, sampled only in the check phase.
REQ-008 Port save, output, 1: memory-block save strobe.
REQ-009 Port rollBack, output, 1: memory-block rollback select.
REQ-010 Port readBuff, output, 1: input-buffer re-read enable.
REQ-011 Port substr, output, 1: output-buffer substitution enable.
REQ-012 Port phase, output, 2: current normal-mode phase index, 0..NPHASE-1.
REQ-013 Port recovering, output, 1: high while in ROLLBACK or SPEED.
REQ-014 Port permFail, output, 1: sticky permanent-fault flag.
REQ-015 Port errCnt, output, CW: saturating count of all detected fails.

Function
REQ-016 States: NORMAL, ROLLBACK, SPEED and PERM; all outputs are registered.
REQ-017 NORMAL: phase advances 0,1,..,NPHASE-1,0 by one per cycle; fail is sampled only at phase 0 (the check phase).
REQ-018 Phase 0 with fail=0: go to phase 1, set save=1, clear the retry counter.
REQ-019 Leaving phase 1 (any NPHASE): save<=0; save is otherwise 0 in phases 2..NPHASE-1.
REQ-020 Phase 0 with fail=1 and retry<MAX_RETRY-1: go to ROLLBACK, set save, rollBack, readBuff and substr to 1, increment retry, increment errCnt.
REQ-021 ROLLBACK lasts 1 cycle: save<=0, go to SPEED with speed counter k=0.
REQ-022 SPEED lasts SPEED_CYCLES cycles; k increments each cycle.
REQ-023 Leaving SPEED at k=0: readBuff<=0.
REQ-024 Leaving SPEED at k=1: substr<=0.
REQ-025 Leaving SPEED at k=SPEED_CYCLES-1: rollBack<=0, save<=1, enter NORMAL at phase 1.
REQ-026 Total recovery length is 1+SPEED_CYCLES cycles, from the first rollBack=1 cycle to the first rollBack=0 cycle.
REQ-027 fail is ignored in ROLLBACK, SPEED, phases 1..NPHASE-1 and PERM.
REQ-028 Phase 0 with fail=1 and retry==MAX_RETRY-1: go to PERM; this takes precedence over ROLLBACK.
REQ-029 On entry to PERM: all four controls <=0, permFail<=1, errCnt incremented.
REQ-030 PERM holds until reset.
REQ-031 errCnt saturates at 2^CW-1 and never wraps.
REQ-032 In ROLLBACK, SPEED and PERM, phase holds 0.
REQ-033 recovering is registered, with the same timing as rollBack.

Reset
REQ-034 While reset is low, asynchronously: state=NORMAL, phase=0, all outputs 0, retry=0, k=0, errCnt=0.
REQ-035 Reset asserted during ROLLBACK, SPEED or PERM aborts immediately to the REQ-034 values; there is no partial completion.
REQ-036 The first rising edge after reset deassertion is treated as phase 0.

Structure
REQ-037 Package ctr_nt_pkg holds the state encoding, the parameter legal-range constants and the default parameter values.
REQ-038 Sub-module ctr_nt_satcnt (saturating CW-bit incrementer) implements errCnt; everything else is flat in ctr_nt_recovery.
REQ-039 Out-of-range parameters are rejected by an elaboration-time check.

Verification (NPHASE=2, SPEED_CYCLES=3, MAX_RETRY=3, CW=8)
REQ-040 Fault-free run: release reset with fail=0 -> save = 1,0,1,0... on successive cycles, rollBack stays 0, errCnt=0.
REQ-041 Single fail at a check edge -> next 4 cycles show rollBack 1,1,1,1; save 1,0,0,0; readBuff 1,1,0,0; substr 1,1,1,0; then rollBack=0, save=1, phase=1; errCnt=1.
REQ-042 fail held high for 3 consecutive check phases -> 2 recoveries, then permFail=1 with all controls 0; errCnt=3; state stays PERM for 100 cycles.
REQ-043 fail pulses only at phase 1 and during SPEED -> no recovery triggered, errCnt=0.
REQ-044 Reset asserted at SPEED k=1 -> all outputs 0 asynchronously; after release, normal save toggling resumes with errCnt=0.
REQ-045 NPHASE=3 fault-free run -> save = 1,0,0 repeating; phase = 1,2,0 repeating.
